// File: rtl/pipe_fetch_issue.sv
// In-order fetch/issue stage: fetches from a local instruction memory, inserts
// bubbles on read-after-write hazards against the last two issue slots, stops on halt.
module pipe_fetch_issue #(
  parameter int         IMEM_DEPTH = 256,
  parameter logic [3:0] HALT_FUNC  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [23:0] ld_data,
  input  logic        start,
  input  logic [7:0]  start_pc,
  input  logic        stall,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        iss_valid,
  output logic        halted,
  output logic [7:0]  pc,
  output logic [15:0] issue_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state_reg;
  logic [23:0]       imem [IMEM_DEPTH];
  logic [23:0]       cand;
  logic [1:0][3:0]   win_rd_reg;
  logic [1:0]        win_v_reg;
  logic [1:0]        hit;

  assign cand = imem[pc];

  // Slot 0 is the most recent issue slot, slot 1 the one before it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_haz
      assign hit[gi] = win_v_reg[gi] &&
                       ((cand[15:12] == win_rd_reg[gi]) || (cand[11:8] == win_rd_reg[gi]));
    end
  endgenerate

  // No reset on the memory so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (ld_en && state_reg == IDLE)
      imem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc         <= 8'h00;
      rs1        <= 4'h0;
      rs2        <= 4'h0;
      rd         <= 4'h0;
      func       <= 4'h0;
      addr       <= 8'h00;
      iss_valid  <= 1'b0;
      halted     <= 1'b0;
      issue_cnt  <= 16'h0000;
      win_rd_reg <= '0;
      win_v_reg  <= 2'b00;
    end else begin
      case (state_reg)
        RUN: begin
          if (!stall) begin
            if (cand[23:20] == HALT_FUNC) begin
              state_reg <= HALT;
              halted    <= 1'b1;
              iss_valid <= 1'b0;
              win_v_reg <= 2'b00;
            end else if (|hit) begin
              // Bubble: an invalid entry enters the window, so at most two in a row.
              iss_valid  <= 1'b0;
              win_v_reg  <= {win_v_reg[0], 1'b0};
              win_rd_reg <= {win_rd_reg[0], 4'h0};
            end else begin
              func       <= cand[23:20];
              rd         <= cand[19:16];
              rs1        <= cand[15:12];
              rs2        <= cand[11:8];
              addr       <= cand[7:0];
              iss_valid  <= 1'b1;
              issue_cnt  <= issue_cnt + 16'h0001;
              pc         <= pc + 8'h01;
              win_v_reg  <= {win_v_reg[0], 1'b1};
              win_rd_reg <= {win_rd_reg[0], cand[19:16]};
            end
          end
        end
        default: begin
          iss_valid <= 1'b0;
          if (start) begin
            state_reg <= RUN;
            pc        <= start_pc;
            halted    <= 1'b0;
            issue_cnt <= 16'h0000;
            win_v_reg <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_issue.sv
// Directed bench for pipe_fetch_issue: basic issue/halt, hazard bubbles, stall,
// pc wrap, reset abort and load-ignored-during-run.
module tb_pipe_fetch_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [23:0] ld_data;
  logic        start;
  logic [7:0]  start_pc;
  logic        stall;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        iss_valid, halted;
  logic [7:0]  pc;
  logic [15:0] issue_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_fetch_issue dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .start_pc(start_pc), .stall(stall),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .iss_valid(iss_valid), .halted(halted), .pc(pc), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [23:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic go(input logic [7:0] spc);
    start = 1'b1; start_pc = spc;
    step();
    start = 1'b0;
  endtask

  // Check issued fields in one transaction line.
  task automatic issue(input string tag, input logic v, input logic [3:0] f, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [7:0] a,
                       input logic [7:0] p, input logic [15:0] c);
    $display("%s: v=%0b func=%h rd=%h rs1=%h rs2=%h addr=%h pc=%h cnt=%0d",
             tag, iss_valid, func, rd, rs1, rs2, addr, pc, issue_cnt);
    chk({tag, ".valid"}, {31'd0, iss_valid}, {31'd0, v});
    chk({tag, ".fields"}, {8'd0, func, rd, rs1, rs2, addr}, {8'd0, f, d, s1, s2, a});
    chk({tag, ".pc"}, {24'd0, pc}, {24'd0, p});
    chk({tag, ".cnt"}, {16'd0, issue_cnt}, {16'd0, c});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst.zero", {pc, issue_cnt, iss_valid, halted, 6'd0},  32'd0);
    chk("rst.fields", {16'd0, func, rd, rs1, rs2} | {24'd0, addr}, 32'd0);
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; start_pc = '0; stall = 1'b0;
    #12;
    do_reset();

    // Basic two-issue program then halt
    load(8'h00, 24'h031210);
    load(8'h01, 24'h546711);
    load(8'h02, 24'hF00000);
    go(8'h00);
    issue("start", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 16'd0);
    step(); issue("b0", 1'b1, 4'h0, 4'h3, 4'h1, 4'h2, 8'h10, 8'h01, 16'd1);
    step(); issue("b1", 1'b1, 4'h5, 4'h4, 4'h6, 4'h7, 8'h11, 8'h02, 16'd2);
    step(); issue("bh", 1'b0, 4'h5, 4'h4, 4'h6, 4'h7, 8'h11, 8'h02, 16'd2);
    chk("bh.halted", {31'd0, halted}, 32'd1);

    // Loads while running must be ignored; rerun from HALT and confirm program intact
    ld_en = 1'b1; ld_addr = 8'h02; ld_data = 24'h012345;
    go(8'h00);
    chk("rr.unhalt", {31'd0, halted}, 32'd0);
    step(); step(); step();
    ld_en = 1'b0;
    issue("rr.h", 1'b0, 4'h5, 4'h4, 4'h6, 4'h7, 8'h11, 8'h02, 16'd2);
    go(8'h00);
    step(); step(); step();
    issue("rr2.h", 1'b0, 4'h5, 4'h4, 4'h6, 4'h7, 8'h11, 8'h02, 16'd2);
    chk("rr2.halted", {31'd0, halted}, 32'd1);

    // Hazard: instr1 reads r3 written by instr0 -> two bubbles
    do_reset();
    load(8'h00, 24'h031200);
    load(8'h01, 24'h153401);
    load(8'h02, 24'hF00000);
    go(8'h00);
    step(); issue("h0", 1'b1, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    step(); issue("hb1", 1'b0, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    step(); issue("hb2", 1'b0, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    step(); issue("h1", 1'b1, 4'h1, 4'h5, 4'h3, 4'h4, 8'h01, 8'h02, 16'd2);
    step(); chk("h.halted", {31'd0, halted}, 32'd1);

    // Stall holds everything, overriding the pending hazard
    go(8'h00);
    step(); issue("s0", 1'b1, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); issue("stall", 1'b1, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    end
    stall = 1'b0;
    step(); issue("sb1", 1'b0, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    step(); issue("sb2", 1'b0, 4'h0, 4'h3, 4'h1, 4'h2, 8'h00, 8'h01, 16'd1);
    step(); issue("s1", 1'b1, 4'h1, 4'h5, 4'h3, 4'h4, 8'h01, 8'h02, 16'd2);

    // pc wrap FE -> FF -> 00 -> 01
    do_reset();
    load(8'hFE, 24'h2100FE);
    load(8'hFF, 24'h2200FF);
    load(8'h00, 24'h230000);
    load(8'h01, 24'hF00000);
    go(8'hFE);
    chk("w.pc0", {24'd0, pc}, 32'hFE);
    step(); issue("w1", 1'b1, 4'h2, 4'h1, 4'h0, 4'h0, 8'hFE, 8'hFF, 16'd1);
    step(); issue("w2", 1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 8'hFF, 8'h00, 16'd2);
    step(); issue("w3", 1'b1, 4'h2, 4'h3, 4'h0, 4'h0, 8'h00, 8'h01, 16'd3);
    step(); chk("w.halted", {31'd0, halted}, 32'd1);
    chk("w.pch", {24'd0, pc}, 32'h01);

    // Reset mid-run aborts; imem survives and re-executes
    go(8'hFE);
    step(); step();
    do_reset();
    go(8'hFE);
    step(); issue("ra1", 1'b1, 4'h2, 4'h1, 4'h0, 4'h0, 8'hFE, 8'hFF, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
